// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending core stores draining in order toward
// data memory, with a word-granular load-hazard check against pending entries.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  input  logic                     MemRead,
  input  logic                     MemReady,
  output logic                     MemWe,
  output logic [31:0]              MemAdr,
  output logic [31:0]              MemWData,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     LoadHit,
  output logic                     Overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [31:0]   adr_mem_q [DEPTH];
  logic [31:0]   adr_mem_d [DEPTH];
  logic [31:0]   dat_mem_q [DEPTH];
  logic [31:0]   dat_mem_d [DEPTH];

  logic          empty, full, pop, push, hit;
  logic [PW-1:0] offset;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Handshake decode: a pop frees a slot for a push at the same edge.
  always_comb begin
    pop  = !empty && MemReady;
    push = MemWrite && (!full || pop);
  end

  // Pointer, occupancy and sticky overflow next-state; pointers wrap naturally.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | (MemWrite && full && !pop);
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
  end

  // Entry storage next-state: write the incoming store at the tail slot.
  always_comb begin
    adr_mem_d = adr_mem_q;
    dat_mem_d = dat_mem_q;
    if (push) begin
      adr_mem_d[tail_q] = DataAdr;
      dat_mem_d[tail_q] = WriteData;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; validity is tracked by pointers and count only.
  always_ff @(posedge clk) begin
    adr_mem_q <= adr_mem_d;
    dat_mem_q <= dat_mem_d;
  end

  // Head presentation and status outputs, all from registered state.
  always_comb begin
    MemWe    = !empty;
    MemAdr   = empty ? '0 : adr_mem_q[head_q];
    MemWData = empty ? '0 : dat_mem_q[head_q];
    Full     = full;
    Empty    = empty;
    Count    = count_q;
    Overflow = overflow_q;
  end

  // Load hazard: an entry is valid when its distance from head is below count;
  // the store being pushed this cycle is not yet in storage, so it never hits.
  always_comb begin
    hit    = 1'b0;
    offset = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - head_q;
      if (({1'b0, offset} < count_q) && (adr_mem_q[i][31:2] == DataAdr[31:2]))
        hit = 1'b1;
    end
    LoadHit = MemRead && hit;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: constant vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead, MemReady;
  logic [31:0] DataAdr, WriteData;
  logic        MemWe, Full, Empty, LoadHit, Overflow;
  logic [31:0] MemAdr, MemWData;
  logic [2:0]  Count;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .MemRead(MemRead), .MemReady(MemReady),
    .MemWe(MemWe), .MemAdr(MemAdr), .MemWData(MemWData), .Full(Full),
    .Empty(Empty), .Count(Count), .LoadHit(LoadHit), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rd;
    logic        rdy;
    logic        hit;   // LoadHit before the edge
    logic [2:0]  cnt;   // state after the edge
    logic [31:0] eadr;
    logic [31:0] edat;
    logic        full;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  logic m_ovf;

  function automatic vec_t v(input int rst, wr, input int unsigned adr, wd,
                             input int rd, rdy, hit, cnt,
                             input int unsigned eadr, edat, input int full, ovf);
    vec_t r;
    r.rst = rst[0]; r.wr = wr[0]; r.adr = adr; r.wd = wd; r.rd = rd[0];
    r.rdy = rdy[0]; r.hit = hit[0]; r.cnt = cnt[2:0]; r.eadr = eadr;
    r.edat = edat; r.full = full[0]; r.ovf = ovf[0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wr, input logic [31:0] adr, input logic [31:0] wd,
                       input logic rd, input logic rdy);
    MemWrite = wr; DataAdr = adr; WriteData = wd; MemRead = rd; MemReady = rdy;
  endtask

  // Called at posedge+1: pulse reset between edges and check immediate clear.
  task automatic do_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    chk("rst_memwe", 32'(MemWe), 32'h0);
    chk("rst_count", 32'(Count), 32'h0);
    chk("rst_empty", 32'(Empty), 32'h1);
    chk("rst_full", 32'(Full), 32'h0);
    chk("rst_memadr", MemAdr, 32'h0);
    chk("rst_memwdata", MemWData, 32'h0);
    chk("rst_loadhit", 32'(LoadHit), 32'h0);
    chk("rst_overflow", 32'(Overflow), 32'h0);
    reset = 1'b0;
    q.delete();
    m_ovf = 1'b0;
  endtask

  // Compare all outputs against the queue model for the current inputs.
  task automatic mcheck();
    logic h;
    h = 1'b0;
    if (MemRead)
      foreach (q[k]) if (q[k].a[31:2] == DataAdr[31:2]) h = 1'b1;
    chk("m_loadhit", 32'(LoadHit), 32'(h));
    chk("m_memwe", 32'(MemWe), 32'(q.size() != 0));
    chk("m_memadr", MemAdr, (q.size() != 0) ? q[0].a : 32'h0);
    chk("m_memwdata", MemWData, (q.size() != 0) ? q[0].d : 32'h0);
    chk("m_count", 32'(Count), 32'(q.size()));
    chk("m_full", 32'(Full), 32'(q.size() == DEPTH));
    chk("m_empty", 32'(Empty), 32'(q.size() == 0));
    chk("m_overflow", 32'(Overflow), 32'(m_ovf));
  endtask

  // One model-checked cycle, entered and left at posedge+1.
  task automatic mstep(input logic wr, input logic [31:0] adr, input logic [31:0] wd,
                       input logic rd, input logic rdy);
    ent_t e;
    drive(wr, adr, wd, rd, rdy);
    #3;
    mcheck();
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (wr) begin
      if (q.size() < DEPTH) begin
        e.a = adr; e.d = wd;
        q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    m_ovf = 1'b0;

    // single store, fill/overflow/drain, full with push+pop, load hazards
    vecs.push_back(v(0,1,100,25,0,1, 0,1,100,25,0,0));
    vecs.push_back(v(0,0,0,0,0,1,    0,0,0,0,0,0));
    vecs.push_back(v(0,1,0,10,0,0,   0,1,0,10,0,0));
    vecs.push_back(v(0,1,4,11,0,0,   0,2,0,10,0,0));
    vecs.push_back(v(0,1,8,12,1,0,   0,3,0,10,0,0));
    vecs.push_back(v(0,1,12,13,1,0,  0,4,0,10,1,0));
    vecs.push_back(v(0,1,16,14,1,0,  0,4,0,10,1,1));
    vecs.push_back(v(0,0,0,0,0,1,    0,3,4,11,0,1));
    vecs.push_back(v(0,0,0,0,0,1,    0,2,8,12,0,1));
    vecs.push_back(v(0,0,0,0,0,1,    0,1,12,13,0,1));
    vecs.push_back(v(0,0,0,0,0,1,    0,0,0,0,0,1));
    vecs.push_back(v(1,0,0,0,0,0,    0,0,0,0,0,0));
    vecs.push_back(v(0,1,0,20,0,0,   0,1,0,20,0,0));
    vecs.push_back(v(0,1,4,21,0,0,   0,2,0,20,0,0));
    vecs.push_back(v(0,1,8,22,0,0,   0,3,0,20,0,0));
    vecs.push_back(v(0,1,12,23,0,0,  0,4,0,20,1,0));
    vecs.push_back(v(0,1,96,7,0,1,   0,4,4,21,1,0));
    vecs.push_back(v(0,0,0,0,0,1,    0,3,8,22,0,0));
    vecs.push_back(v(0,0,0,0,0,1,    0,2,12,23,0,0));
    vecs.push_back(v(0,0,98,0,1,1,   1,1,96,7,0,0));
    vecs.push_back(v(0,0,98,0,1,1,   1,0,0,0,0,0));

    @(posedge clk);
    #1;
    chk("init_count", 32'(Count), 32'h0);
    chk("init_memwe", 32'(MemWe), 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
      end else begin
        drive(vecs[i].wr, vecs[i].adr, vecs[i].wd, vecs[i].rd, vecs[i].rdy);
        #3;
        chk($sformatf("v%0d_loadhit", i), 32'(LoadHit), 32'(vecs[i].hit));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_count", i), 32'(Count), 32'(vecs[i].cnt));
        chk($sformatf("v%0d_memwe", i), 32'(MemWe), 32'(vecs[i].cnt != 0));
        chk($sformatf("v%0d_memadr", i), MemAdr, vecs[i].eadr);
        chk($sformatf("v%0d_memwdata", i), MemWData, vecs[i].edat);
        chk($sformatf("v%0d_full", i), 32'(Full), 32'(vecs[i].full));
        chk($sformatf("v%0d_empty", i), 32'(Empty), 32'(vecs[i].cnt == 0));
        chk($sformatf("v%0d_overflow", i), 32'(Overflow), 32'(vecs[i].ovf));
      end
    end

    // load hazard against a pending store, including same-cycle push exclusion
    do_reset();
    mstep(1'b1, 32'd96, 32'd55, 1'b0, 1'b0);
    mstep(1'b0, 32'd98, 32'd0, 1'b1, 1'b0);
    chk("lh_98", 32'(LoadHit), 32'h1);
    mstep(1'b0, 32'd100, 32'd0, 1'b1, 1'b0);
    mstep(1'b0, 32'd96, 32'd0, 1'b0, 1'b0);
    mstep(1'b1, 32'd300, 32'd5, 1'b1, 1'b0);
    mstep(1'b0, 32'd302, 32'd0, 1'b1, 1'b0);

    // asynchronous reset with two entries pending, then no further drain
    chk("pre_rst_count", 32'(Count), 32'h2);
    do_reset();
    for (int i = 0; i < 3; i++) mstep(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // pointer wrap: back-to-back push/pop keeps occupancy at one
    do_reset();
    for (int i = 0; i < 10; i++) begin
      mstep(1'b1, 32'(1000 + 4 * i), 32'(i + 1), 1'b0, 1'b1);
      chk("wrap_cnt_le1", 32'(Count <= 3'd1), 32'h1);
    end
    mstep(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    mcheck();

    // randomized traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      mstep($urandom_range(0, 9) < 6,
            32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)),
            $urandom,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 5);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #3;
    mcheck();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
